// File: rtl/host_mem_arbiter.sv
// host_mem_arbiter
//   Bridges the asynchronous pad-level host debug bus into the clk domain.
//   The host strobes are synchronised and a four-register window is decoded.
//   One synchronous memory port is shared between the host and the MU0 core,
//   and the host always has priority. The block also drives MU0 run/step control.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   host_ncs/nwe/nre  asynchronous active-low host strobes
//   host_addr         host register address (only 0..3 are mapped)
//   host_data_in      host write data
//   host_data_out     combinational register read data for host_addr
//   cpu_mem_req/wr    core memory request and its direction
//   cpu_addr/wdata    core address and write data
//   cpu_grant         core access performed this cycle (combinational)
//   mem_en/wr/addr/wdata  memory port; mem_rdata is valid one cycle after a read
//   cpu_run           core free-run enable
//   cpu_step          one-cycle single-step pulse
module host_mem_arbiter #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_ncs,
   input  logic              host_nwe,
   input  logic              host_nre,
   input  logic [5:0]        host_addr,
   input  logic [DATA_W-1:0] host_data_in,
   output logic [DATA_W-1:0] host_data_out,
   input  logic              cpu_mem_req,
   input  logic              cpu_mem_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_grant,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_run,
   output logic              cpu_step
);

   localparam int unsigned SYNC_MSB = SYNC_STAGES - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      H_WR  = 2'd1,
      H_RD  = 2'd2,
      H_CAP = 2'd3
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   pref;
   logic [DATA_W-1:0]   wr_data_q;
   logic                pend, pend_wr, ovf;

   // The synchronisers carry the active-low form, so a reset value of 1 means inactive.
   logic [SYNC_STAGES-1:0] wr_sync_n, rd_sync_n;
   logic                   wr_prev_n, rd_prev_n;
   logic                   wr_raw_n, rd_raw_n;
   logic                   wr_evt, rd_end;

   logic       win_hit;
   logic [1:0] reg_sel;
   logic       ptr_load, data_wr, ctrl_wr, data_rd_end, stat_rd_end;
   logic       need_mem, busy;

   logic       ptr_inc_fsm, pref_load, pend_clr;

   assign wr_raw_n = host_ncs | host_nwe;
   assign rd_raw_n = host_ncs | host_nre;

   // Strobe synchronisers and their edge-detect history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_sync_n <= '1;
         rd_sync_n <= '1;
         wr_prev_n <= 1'b1;
         rd_prev_n <= 1'b1;
      end else begin
         wr_sync_n <= {wr_sync_n[SYNC_STAGES-2:0], wr_raw_n};
         rd_sync_n <= {rd_sync_n[SYNC_STAGES-2:0], rd_raw_n};
         wr_prev_n <= wr_sync_n[SYNC_MSB];
         rd_prev_n <= rd_sync_n[SYNC_MSB];
      end
   end

   // A write becomes active (the synced level goes low); a read ends (the synced level goes high)
   assign wr_evt = wr_prev_n & ~wr_sync_n[SYNC_MSB];
   assign rd_end = ~rd_prev_n & rd_sync_n[SYNC_MSB];

   // Register window decode on the raw address; the host holds it across the event
   assign win_hit     = (host_addr[5:2] == 4'd0);
   assign reg_sel     = host_addr[1:0];
   assign ptr_load    = wr_evt & win_hit & (reg_sel == 2'd0);
   assign data_wr     = wr_evt & win_hit & (reg_sel == 2'd1);
   assign ctrl_wr     = wr_evt & win_hit & (reg_sel == 2'd2);
   assign data_rd_end = rd_end & win_hit & (reg_sel == 2'd1);
   assign stat_rd_end = rd_end & win_hit & (reg_sel == 2'd3);
   assign need_mem    = ptr_load | data_wr | data_rd_end;

   assign busy = (state != IDLE) | pend;

   // Host read mux; reads have no side effects until the strobe ends
   always_comb begin
      host_data_out = '0;
      if (win_hit) begin
         case (reg_sel)
            2'd0:    host_data_out = DATA_W'(ptr);
            2'd1:    host_data_out = pref;
            2'd2:    host_data_out = DATA_W'(cpu_run);
            default: host_data_out = DATA_W'({ovf, cpu_run, busy});
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   // Next state and memory port steering; the core is served only when the host is quiet
   always_comb begin
      state_d     = state;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = ptr;
      mem_wdata   = wr_data_q;
      cpu_grant   = 1'b0;
      ptr_inc_fsm = 1'b0;
      pref_load   = 1'b0;
      pend_clr    = 1'b0;
      case (state)
         IDLE: begin
            if (pend) begin
               state_d  = pend_wr ? H_WR : H_RD;
               pend_clr = 1'b1;
            end else if (cpu_mem_req) begin
               cpu_grant = 1'b1;
               mem_en    = 1'b1;
               mem_wr    = cpu_mem_wr;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
            end
         end
         H_WR: begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            ptr_inc_fsm = 1'b1;
            state_d     = H_RD;
         end
         H_RD: begin
            mem_en  = 1'b1;
            state_d = H_CAP;
         end
         H_CAP: begin
            pref_load = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // One-deep host request queue; a memory event that arrives while the queue is full is dropped and flagged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend      <= 1'b0;
         pend_wr   <= 1'b0;
         ovf       <= 1'b0;
         wr_data_q <= '0;
      end else begin
         if (pend_clr) pend <= 1'b0;
         if (need_mem) begin
            if (pend) begin
               ovf <= 1'b1;
            end else begin
               pend    <= 1'b1;
               pend_wr <= data_wr;
               if (data_wr) wr_data_q <= host_data_in;
            end
         end
         if (stat_rd_end) ovf <= 1'b0;
      end
   end

   // Pointer: a host load wins; otherwise the write-complete and read-end increments add (modulo 2^ADDR_W)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (ptr_load) begin
         ptr <= host_data_in[ADDR_W-1:0];
      end else begin
         ptr <= ptr + ADDR_W'(ptr_inc_fsm) + ADDR_W'(data_rd_end);
      end
   end

   // Prefetch register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          pref <= '0;
      else if (pref_load) pref <= mem_rdata;
   end

   // Run/step control
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_run  <= 1'b0;
         cpu_step <= 1'b0;
      end else begin
         cpu_step <= ctrl_wr & host_data_in[1];
         if (ctrl_wr) cpu_run <= host_data_in[0];
      end
   end

endmodule

// File: tb/tb_host_mem_arbiter.sv
module tb_host_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        host_ncs = 1'b1, host_nwe = 1'b1, host_nre = 1'b1;
   logic [5:0]  host_addr = '0;
   logic [15:0] host_data_in = '0;
   logic [15:0] host_data_out;
   logic        cpu_mem_req = 1'b0, cpu_mem_wr = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_grant, mem_en, mem_wr;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        cpu_run, cpu_step;

   int n_checks = 0;
   int n_fail   = 0;

   host_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .host_ncs(host_ncs), .host_nwe(host_nwe), .host_nre(host_nre),
      .host_addr(host_addr), .host_data_in(host_data_in), .host_data_out(host_data_out),
      .cpu_mem_req(cpu_mem_req), .cpu_mem_wr(cpu_mem_wr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_grant(cpu_grant),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .cpu_run(cpu_run), .cpu_step(cpu_step)
   );

   always #5 clk = ~clk;

   // Synchronous memory model: mem[i] starts as i ^ 16'hA5A5
   logic [15:0] mem [0:4095];
   logic [11:0] last_rd_addr = '0;
   logic [11:0] last_wr_addr = '0;
   logic [15:0] last_wr_data = '0;
   int          wr_cnt = 0;
   int          step_cnt = 0;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            last_wr_addr  <= mem_addr;
            last_wr_data  <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
         end else begin
            mem_rdata    <= mem[mem_addr];
            last_rd_addr <= mem_addr;
         end
      end
   end

   always @(negedge clk) if (cpu_step) step_cnt <= step_cnt + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Combinational register peek; no strobes are active, so there are no side effects
   task automatic peek(input logic [5:0] a, output logic [15:0] v);
      @(negedge clk);
      host_addr = a;
      #1 v = host_data_out;
   endtask

   task automatic host_write(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      host_addr = a; host_data_in = d; host_ncs = 1'b0; host_nwe = 1'b0;
      repeat (5) @(negedge clk);
      host_nwe = 1'b1; host_ncs = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic host_read_end(input logic [5:0] a);
      @(negedge clk);
      host_addr = a; host_ncs = 1'b0; host_nre = 1'b0;
      repeat (4) @(negedge clk);
      host_nre = 1'b1; host_ncs = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      logic [15:0] v;
      int lo, wc0, sc0;
      bit seen;
      for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA5A5;
      mem_rdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_grant", cpu_grant, 0);
      check_eq("rst_run", cpu_run, 0);
      check_eq("rst_step", cpu_step, 0);
      peek(6'h03, v); check_eq("rst_status", v, 16'h0000);
      peek(6'h00, v); check_eq("rst_ptr", v, 16'h0000);

      // 1: PTR load triggers a prefetch
      host_write(6'h00, 16'h0010);
      check_eq("t1_rd_addr", last_rd_addr, 12'h010);
      peek(6'h00, v); check_eq("t1_ptr", v, 16'h0010);
      peek(6'h01, v); check_eq("t1_pref", v, 16'hA5B5);
      peek(6'h03, v); check_eq("t1_busy_fell", v, 16'h0000);

      // 2: DATA write at PTR, then PTR++ and prefetch
      host_write(6'h01, 16'hBEEF);
      check_eq("t2_wr_addr", last_wr_addr, 12'h010);
      check_eq("t2_wr_data", last_wr_data, 16'hBEEF);
      check_eq("t2_mem", mem[12'h010], 16'hBEEF);
      peek(6'h00, v); check_eq("t2_ptr", v, 16'h0011);
      peek(6'h01, v); check_eq("t2_pref", v, 16'hA5B4);

      // 3: PTR wraps on DATA read-end
      host_write(6'h00, 16'h0FFF);
      peek(6'h01, v); check_eq("t3_pref_fff", v, 16'hAA5A);
      host_read_end(6'h01);
      peek(6'h00, v); check_eq("t3_ptr_wrap", v, 16'h0000);
      peek(6'h01, v); check_eq("t3_pref_000", v, 16'hA5A5);

      // Unmapped address: write ignored, read returns 0
      wc0 = wr_cnt;
      host_write(6'h05, 16'h0777);
      peek(6'h00, v); check_eq("unmap_ptr", v, 16'h0000);
      check_eq("unmap_no_wr", 32'(wr_cnt - wc0), 0);
      peek(6'h06, v); check_eq("unmap_rd", v, 16'h0000);

      // 4: core held off for pend + H_WR + H_RD + H_CAP
      @(negedge clk);
      cpu_mem_req = 1'b1; cpu_mem_wr = 1'b0; cpu_addr = 12'h123;
      #1;
      check_eq("t4_grant_pre", cpu_grant, 1);
      check_eq("t4_core_addr", mem_addr, 12'h123);
      @(negedge clk);
      host_addr = 6'h01; host_data_in = 16'h1234; host_ncs = 1'b0; host_nwe = 1'b0;
      lo = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (!cpu_grant) lo++;
         if (i == 4) begin host_nwe = 1'b1; host_ncs = 1'b1; end
      end
      check_eq("t4_grant_low_cycles", lo, 4);
      check_eq("t4_grant_post", cpu_grant, 1);
      cpu_mem_req = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t4_mem0", mem[12'h000], 16'h1234);
      peek(6'h00, v); check_eq("t4_ptr", v, 16'h0001);
      peek(6'h01, v); check_eq("t4_pref", v, 16'hA5A4);

      // 5: three DATA write events two cycles apart; the third finds pend set
      wc0 = wr_cnt;
      @(negedge clk);
      host_addr = 6'h01; host_data_in = 16'h5555; host_ncs = 1'b0;
      for (int i = 0; i < 3; i++) begin
         host_nwe = 1'b0; @(negedge clk);
         host_nwe = 1'b1; @(negedge clk);
      end
      repeat (2) @(negedge clk);
      host_ncs = 1'b1;
      host_addr = 6'h03;
      #1 check_eq("t5_status_busy_ovf", host_data_out, 16'h0005);
      repeat (12) @(negedge clk);
      check_eq("t5_two_writes", 32'(wr_cnt - wc0), 2);
      peek(6'h03, v); check_eq("t5_status_idle", v, 16'h0004);
      peek(6'h00, v); check_eq("t5_ptr", v, 16'h0003);
      peek(6'h01, v); check_eq("t5_pref", v, 16'hA5A6);
      host_read_end(6'h03);
      peek(6'h03, v); check_eq("t5_ovf_cleared", v, 16'h0000);

      // 6: CTRL run + step
      sc0 = step_cnt;
      host_write(6'h02, 16'h0003);
      check_eq("t6_run", cpu_run, 1);
      check_eq("t6_step_pulses", 32'(step_cnt - sc0), 1);
      peek(6'h03, v); check_eq("t6_status", v, 16'h0002);

      // Reset while in H_WR
      @(negedge clk);
      host_addr = 6'h01; host_data_in = 16'h9999; host_ncs = 1'b0; host_nwe = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (mem_en && mem_wr) seen = 1'b1;
      end
      check_eq("rst_hwr_seen", seen, 1);
      reset = 1'b1;
      host_nwe = 1'b1; host_ncs = 1'b1;
      #1;
      check_eq("rst2_mem_en", mem_en, 0);
      check_eq("rst2_mem_wr", mem_wr, 0);
      check_eq("rst2_run", cpu_run, 0);
      check_eq("rst2_step", cpu_step, 0);
      check_eq("rst2_grant", cpu_grant, 0);
      check_eq("rst2_pref", host_data_out, 16'h0000);
      host_addr = 6'h03;
      #1 check_eq("rst2_status", host_data_out, 16'h0000);
      host_addr = 6'h00;
      #1 check_eq("rst2_ptr", host_data_out, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
